// File: rtl/sprite_layer_arbiter.sv
`timescale 1ns/1ps
// Two-stage per-pixel arbiter between sprite layers and background, with frame-rotated priority and overlap flags.
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENT_KEY_EN.
module sprite_layer_arbiter #(
    parameter int              N_LAYERS   = 10,
    parameter int              DW         = 12,
    parameter int              ROT_FRAMES = 60,
    parameter int              FIXED0     = 1,
    parameter logic [DW-1:0]   KEY_COLOR  = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [N_LAYERS-1:0]    layer_en,
    input  logic [N_LAYERS*DW-1:0] layer_data,
    input  logic [DW-1:0]          bg_data,
    output logic [DW-1:0]          VGA_data,
    output logic                   out_valid,
    output logic [3:0]             win_idx,
    output logic [3:0]             prio_ptr,
    output logic [N_LAYERS-1:0]    overlap_mask,
    output logic                   overlap_irq
);

    localparam logic [3:0] BG_IDX   = 4'hF;
    localparam logic [3:0] PTR_BASE = (FIXED0 != 0) ? 4'd1 : 4'd0;
    localparam logic [3:0] LAST_IDX = 4'(N_LAYERS - 1);
    localparam logic [7:0] ROT_LAST = 8'(ROT_FRAMES - 1);
    localparam logic [N_LAYERS-1:0] ONE_MASK = {{(N_LAYERS-1){1'b0}}, 1'b1};

    logic                   s1_valid_q, s1_valid_d;
    logic [N_LAYERS-1:0]    s1_en_q, s1_en_d;
    logic [N_LAYERS*DW-1:0] s1_data_q, s1_data_d;
    logic [DW-1:0]          s1_bg_q, s1_bg_d;
    logic [3:0]             s1_win_q, s1_win_d;
    logic [DW-1:0]          vga_q, vga_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0]             win_idx_q, win_idx_d;
    logic [3:0]             prio_ptr_q, prio_ptr_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [N_LAYERS-1:0]    acc_q, acc_d;
    logic [N_LAYERS-1:0]    overlap_mask_q, overlap_mask_d;
    logic                   overlap_irq_q, overlap_irq_d;

    logic [N_LAYERS-1:0]    eff_en;
    logic [N_LAYERS-1:0]    ov_contrib;

`ifdef SPRITE_TRANSPARENT_KEY_EN
    always_comb begin
        eff_en = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            eff_en[i] = layer_en[i] && (layer_data[i*DW +: DW] != KEY_COLOR);
        end
    end
`else
    logic [DW-1:0] unused_key_color;
    assign unused_key_color = KEY_COLOR;
    assign eff_en = layer_en;
`endif

    // Cyclic scan from the priority pointer; layer 0 is handled up front when it is pinned.
    always_comb begin
        logic [4:0] idx;
        logic       found;
        idx      = '0;
        found    = 1'b0;
        s1_win_d = BG_IDX;
        if ((FIXED0 != 0) && eff_en[0]) begin
            s1_win_d = 4'd0;
        end else begin
            for (int k = 0; k < N_LAYERS; k++) begin
                idx = {1'b0, prio_ptr_q} + 5'(k);
                if (idx >= 5'(N_LAYERS)) begin
                    idx = idx - 5'(N_LAYERS);
                end
                if (!found && eff_en[idx[3:0]] && !((FIXED0 != 0) && (idx == 5'd0))) begin
                    s1_win_d = idx[3:0];
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        vga_d = s1_bg_q;
        if (s1_win_q != BG_IDX) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                if (s1_win_q == 4'(i)) begin
                    vga_d = s1_data_q[i*DW +: DW];
                end
            end
        end
        if (!s1_valid_q) begin
            vga_d = vga_q;
        end
    end

    assign ov_contrib = (s1_valid_q && ((s1_en_q & (s1_en_q - ONE_MASK)) != '0)) ? s1_en_q : '0;

    always_comb begin
        s1_valid_d     = pix_valid;
        s1_en_d        = s1_en_q;
        s1_data_d      = s1_data_q;
        s1_bg_d        = s1_bg_q;
        out_valid_d    = s1_valid_q;
        win_idx_d      = s1_valid_q ? s1_win_q : win_idx_q;
        prio_ptr_d     = prio_ptr_q;
        frame_cnt_d    = frame_cnt_q;
        acc_d          = acc_q | ov_contrib;
        overlap_mask_d = overlap_mask_q;
        overlap_irq_d  = 1'b0;

        if (pix_valid) begin
            s1_en_d   = eff_en;
            s1_data_d = layer_data;
            s1_bg_d   = bg_data;
        end

        // Frame close: publish the finished frame and start fresh with this cycle's overlap only.
        if (frame_start) begin
            overlap_mask_d = acc_q;
            overlap_irq_d  = (acc_q != '0);
            acc_d          = ov_contrib;
            if (frame_cnt_q == ROT_LAST) begin
                frame_cnt_d = '0;
                prio_ptr_d  = (prio_ptr_q == LAST_IDX) ? PTR_BASE : prio_ptr_q + 4'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_en_q        <= '0;
            s1_data_q      <= '0;
            s1_bg_q        <= '0;
            s1_win_q       <= BG_IDX;
            vga_q          <= '0;
            out_valid_q    <= 1'b0;
            win_idx_q      <= BG_IDX;
            prio_ptr_q     <= PTR_BASE;
            frame_cnt_q    <= '0;
            acc_q          <= '0;
            overlap_mask_q <= '0;
            overlap_irq_q  <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_en_q        <= s1_en_d;
            s1_data_q      <= s1_data_d;
            s1_bg_q        <= s1_bg_d;
            s1_win_q       <= pix_valid ? s1_win_d : s1_win_q;
            vga_q          <= vga_d;
            out_valid_q    <= out_valid_d;
            win_idx_q      <= win_idx_d;
            prio_ptr_q     <= prio_ptr_d;
            frame_cnt_q    <= frame_cnt_d;
            acc_q          <= acc_d;
            overlap_mask_q <= overlap_mask_d;
            overlap_irq_q  <= overlap_irq_d;
        end
    end

    assign VGA_data     = vga_q;
    assign out_valid    = out_valid_q;
    assign win_idx      = win_idx_q;
    assign prio_ptr     = prio_ptr_q;
    assign overlap_mask = overlap_mask_q;
    assign overlap_irq  = overlap_irq_q;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
`timescale 1ns/1ps
// Directed bench for sprite_layer_arbiter (N_LAYERS=10, FIXED0=1, ROT_FRAMES=2).
module tb_sprite_layer_arbiter;

    localparam int N  = 10;
    localparam int DW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_start = 1'b0;
    logic            pix_valid = 1'b0;
    logic [N-1:0]    layer_en = '0;
    logic [N*DW-1:0] layer_data = '0;
    logic [DW-1:0]   bg_data = '0;
    logic [DW-1:0]   VGA_data;
    logic            out_valid;
    logic [3:0]      win_idx;
    logic [3:0]      prio_ptr;
    logic [N-1:0]    overlap_mask;
    logic            overlap_irq;

    int errors = 0;
    int checks = 0;

    logic [N*DW-1:0] base_data;

    typedef struct {
        logic [N-1:0]  en;
        logic [DW-1:0] bg;
        logic [3:0]    win;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs[6];

    sprite_layer_arbiter #(
        .N_LAYERS(N), .DW(DW), .ROT_FRAMES(2), .FIXED0(1), .KEY_COLOR(12'h000)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .layer_en(layer_en), .layer_data(layer_data), .bg_data(bg_data),
        .VGA_data(VGA_data), .out_valid(out_valid), .win_idx(win_idx),
        .prio_ptr(prio_ptr), .overlap_mask(overlap_mask), .overlap_irq(overlap_irq)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then advance to 1ns past the capturing edge.
    task automatic applyStimulus(input logic fs, input logic pv, input logic [N-1:0] en,
                                 input logic [N*DW-1:0] ld, input logic [DW-1:0] bg);
        frame_start = fs;
        pix_valid   = pv;
        layer_en    = en;
        layer_data  = ld;
        bg_data     = bg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, base_data, 12'h0F0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkPixel(input string name, input logic [3:0] w, input logic [DW-1:0] d);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_win"}, 32'(win_idx), 32'(w));
        checkOutput({name, "_data"}, 32'(VGA_data), 32'(d));
    endtask

    initial begin
        logic [8:0]    bb_pv;
        logic [3:0]    bb_layer[9];
        logic [DW-1:0] bb_data[9];
        logic [N*DW-1:0] key_data;

        for (int i = 0; i < N; i++) begin
            base_data[i*DW +: DW] = {4'h3, 4'(i), 4'h0};
        end
        base_data[0*DW +: DW] = 12'hFFF;
        base_data[2*DW +: DW] = 12'hF00;

        vecs[0] = '{en: 10'b00_0000_0000, bg: 12'h0F0, win: 4'hF, data: 12'h0F0};
        vecs[1] = '{en: 10'b00_0000_0101, bg: 12'h0F0, win: 4'd0, data: 12'hFFF};
        vecs[2] = '{en: 10'b00_0000_1010, bg: 12'h0F0, win: 4'd1, data: 12'h310};
        vecs[3] = '{en: 10'b10_0000_0000, bg: 12'h0F0, win: 4'd9, data: 12'h390};
        vecs[4] = '{en: 10'b10_0000_0100, bg: 12'h0F0, win: 4'd2, data: 12'hF00};
        vecs[5] = '{en: 10'b00_0010_0001, bg: 12'h0F0, win: 4'd0, data: 12'hFFF};

        // Reset state
        rst = 1'b1;
        idle();
        idle();
        checkOutput("rst_vga", 32'(VGA_data), 32'h0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_win", 32'(win_idx), 32'hF);
        checkOutput("rst_ptr", 32'(prio_ptr), 32'd1);
        checkOutput("rst_mask", 32'(overlap_mask), 32'h0);
        checkOutput("rst_irq", 32'(overlap_irq), 32'd0);
        rst = 1'b0;
        idle();

        // Table vectors, each a single pixel followed by its two-cycle latency
        for (int v = 0; v < 6; v++) begin
            applyStimulus(1'b0, 1'b1, vecs[v].en, base_data, vecs[v].bg);
            checkOutput($sformatf("vec%0d_lat1", v), 32'(out_valid), 32'd0);
            idle();
            checkPixel($sformatf("vec%0d", v), vecs[v].win, vecs[v].data);
        end

        // Frame close publishes overlaps from vectors 1,2,4,5
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("frame1_mask", 32'(overlap_mask), 32'h22F);
        checkOutput("frame1_irq", 32'(overlap_irq), 32'd1);
        checkOutput("frame1_ptr", 32'(prio_ptr), 32'd1);
        idle();
        checkOutput("frame1_irq_pulse", 32'(overlap_irq), 32'd0);

        // Second frame_start completes the rotation period
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("rot_ptr2", 32'(prio_ptr), 32'd2);
        applyStimulus(1'b0, 1'b1, 10'b00_0000_1010, base_data, 12'h0F0);
        idle();
        checkPixel("rot_win3", 4'd3, 12'h330);

        for (int p = 3; p <= 10; p++) begin
            applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
            idle();
            applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
            checkOutput($sformatf("rot_ptr_step%0d", p), 32'(prio_ptr), (p == 10) ? 32'd1 : 32'(p));
        end

        // frame_start coincident with a pixel: that pixel still sees the old pointer
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        idle();
        applyStimulus(1'b1, 1'b1, 10'b00_0000_1010, base_data, 12'h0F0);
        applyStimulus(1'b0, 1'b1, 10'b00_0000_1010, base_data, 12'h0F0);
        checkPixel("coinc_old_ptr", 4'd1, 12'h310);
        idle();
        checkPixel("coinc_new_ptr", 4'd3, 12'h330);
        checkOutput("coinc_ptr", 32'(prio_ptr), 32'd2);

        // Back-to-back stream with one bubble
        bb_pv = 9'b1_1110_1111;
        bb_layer = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8};
        bb_data  = '{12'h310, 12'hF00, 12'h330, 12'h340, 12'h000, 12'h350, 12'h360, 12'h370, 12'h380};
        for (int c = 0; c <= 9; c++) begin
            if (c < 9) begin
                applyStimulus(1'b0, bb_pv[c], 10'(1) << bb_layer[c], base_data, 12'h0F0);
            end else begin
                idle();
            end
            if (c >= 1) begin
                checkOutput($sformatf("bb%0d_valid", c - 1), 32'(out_valid), 32'(bb_pv[c-1]));
                if (bb_pv[c-1]) begin
                    checkOutput($sformatf("bb%0d_win", c - 1), 32'(win_idx), 32'(bb_layer[c-1]));
                    checkOutput($sformatf("bb%0d_data", c - 1), 32'(VGA_data), 32'(bb_data[c-1]));
                end
            end
        end
        idle();
        checkOutput("bb_tail_valid", 32'(out_valid), 32'd0);

        // Overlap then reset mid-stream with more overlap pending
        applyStimulus(1'b0, 1'b1, 10'b00_0011_0000, base_data, 12'h0F0);
        idle();
        checkPixel("pre_rst_pix", 4'd4, 12'h340);
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("pre_rst_mask", 32'(overlap_mask), 32'h03A);
        checkOutput("pre_rst_irq", 32'(overlap_irq), 32'd1);
        applyStimulus(1'b0, 1'b1, 10'b00_1100_0000, base_data, 12'h0F0);
        idle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 10'b00_1100_0000, base_data, 12'h0F0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_mask", 32'(overlap_mask), 32'h0);
        checkOutput("mid_rst_ptr", 32'(prio_ptr), 32'd1);
        checkOutput("mid_rst_win", 32'(win_idx), 32'hF);
        checkOutput("mid_rst_vga", 32'(VGA_data), 32'h0);
        rst = 1'b0;
        idle();
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("post_rst_irq", 32'(overlap_irq), 32'd0);
        checkOutput("post_rst_mask", 32'(overlap_mask), 32'h0);

        // Colour-key pixel on layer 1 against a visible layer 2
        key_data = base_data;
        key_data[1*DW +: DW] = 12'h000;
        key_data[2*DW +: DW] = 12'h00F;
        applyStimulus(1'b0, 1'b1, 10'b00_0000_0110, key_data, 12'h0F0);
        idle();
`ifdef SPRITE_TRANSPARENT_KEY_EN
        checkPixel("key_pix", 4'd2, 12'h00F);
        idle();
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("key_mask", 32'(overlap_mask), 32'h0);
        checkOutput("key_irq", 32'(overlap_irq), 32'd0);
`else
        checkPixel("key_pix", 4'd1, 12'h000);
        idle();
        applyStimulus(1'b1, 1'b0, '0, base_data, 12'h0F0);
        checkOutput("key_mask", 32'(overlap_mask), 32'h006);
        checkOutput("key_irq", 32'(overlap_irq), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
